// File: rtl/traffic_multi_phase.sv
// Round-robin N-approach traffic controller with pedestrian walk interval and early green cut-off.
// Optional flashing-yellow override (flash_req input) is built when TRAFFIC_FLASH_EN is defined.
module traffic_multi_phase #(
  parameter int CLK_HZ      = 100000000,
  parameter int N_PHASES    = 2,
  parameter int T_GREEN     = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 1,
  parameter int T_PED_WALK  = 5,
  parameter int T_MIN_GREEN = 4,
  localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_PHASES-1:0] ped_btn,
`ifdef TRAFFIC_FLASH_EN
  input  logic                flash_req,
`endif
  output logic [N_PHASES-1:0] led_r,
  output logic [N_PHASES-1:0] led_y,
  output logic [N_PHASES-1:0] led_g,
  output logic [N_PHASES-1:0] ped_walk,
  output logic [7:0]          seconds_left,
  output logic [2:0]          state,
  output logic [PW-1:0]       phase
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(CLK_HZ - 1);
  localparam logic [7:0]    CUT_SEC    = 8'(T_GREEN + 1 - T_MIN_GREEN);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

  typedef enum logic [2:0] {
    S_GREEN   = 3'd0,
    S_YELLOW  = 3'd1,
    S_ALL_RED = 3'd2,
    S_PED     = 3'd3,
    S_FLASH   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [7:0]          sec_q, sec_d;
  logic [N_PHASES-1:0] req_q, req_d;
  logic [N_PHASES-1:0] walk_q, walk_d;
  logic [N_PHASES-1:0] clr;
  logic [N_PHASES-1:0] sync1_q, sync2_q, prev_q, rise;
  logic [CW-1:0]       cnt_q;
  logic                tick;

`ifdef TRAFFIC_FLASH_EN
  logic fsync1_q, fsync2_q, blink_q, blink_d;
`endif

  assign tick = (cnt_q == CNT_MAX);
  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Buttons are asynchronous: two flops for metastability, a third to find the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ped_btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

`ifdef TRAFFIC_FLASH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsync1_q <= 1'b0;
      fsync2_q <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      fsync1_q <= flash_req;
      fsync2_q <= fsync1_q;
      blink_q  <= blink_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ALL_RED;
      phase_q <= '0;
      sec_q   <= 8'(T_ALL_RED);
      req_q   <= '0;
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sec_q   <= sec_d;
      req_q   <= req_d;
      walk_q  <= walk_d;
    end
  end

  // Decisions use the registered request, so a press landing on a tick counts from the next tick.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sec_d   = sec_q;
    walk_d  = walk_q;
    clr     = '0;
`ifdef TRAFFIC_FLASH_EN
    blink_d = blink_q;
    if (fsync2_q) begin
      state_d = S_FLASH;
      if (state_q != S_FLASH) begin
        blink_d = 1'b1;
        sec_d   = 8'd0;
        walk_d  = '0;
      end else if (tick) begin
        blink_d = ~blink_q;
      end
    end else if (state_q == S_FLASH) begin
      state_d = S_ALL_RED;
      sec_d   = 8'(T_ALL_RED);
    end else
`endif
    if (tick) begin
      if (sec_q > 8'd1 && !(state_q == S_GREEN && |req_q && sec_q <= CUT_SEC)) begin
        sec_d = sec_q - 8'd1;
      end else begin
        case (state_q)
          S_GREEN: begin
            state_d = S_YELLOW;
            sec_d   = 8'(T_YELLOW);
          end
          S_YELLOW: begin
            state_d = S_ALL_RED;
            sec_d   = 8'(T_ALL_RED);
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
          end
          S_ALL_RED: begin
            if (|req_q) begin
              state_d = S_PED;
              sec_d   = 8'(T_PED_WALK);
              walk_d  = req_q;
              clr     = req_q;
            end else begin
              state_d = S_GREEN;
              sec_d   = 8'(T_GREEN);
            end
          end
          S_PED: begin
            state_d = S_GREEN;
            sec_d   = 8'(T_GREEN);
            walk_d  = '0;
          end
          default: ;
        endcase
      end
    end
    req_d = (req_q & ~clr) | rise;
  end

  always_comb begin
    led_r    = '1;
    led_y    = '0;
    led_g    = '0;
    ped_walk = '0;
    case (state_q)
      S_GREEN: begin
        led_r[phase_q] = 1'b0;
        led_g[phase_q] = 1'b1;
      end
      S_YELLOW: begin
        led_r[phase_q] = 1'b0;
        led_y[phase_q] = 1'b1;
      end
      S_PED: ped_walk = walk_q;
`ifdef TRAFFIC_FLASH_EN
      S_FLASH: begin
        led_r = '0;
        led_y = {N_PHASES{blink_q}};
      end
`endif
      default: ;
    endcase
  end

  assign seconds_left = sec_q;
  assign state        = state_q;
  assign phase        = phase_q;

endmodule

// File: tb/tb_traffic_multi_phase.sv
// Self-checking bench for traffic_multi_phase: directed scenarios plus random presses against
// an interval-level reference model. Define TRAFFIC_FLASH_EN to also exercise the flash override.
module tb_traffic_multi_phase;

  localparam int CLK_HZ = 10, N = 3, T_GREEN = 4, T_YELLOW = 2, T_ALL_RED = 1;
  localparam int T_PED = 3, T_MIN = 2;
  localparam int K_GREEN = 0, K_YELLOW = 1, K_ALL_RED = 2, K_PED = 3, K_FLASH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pedBtn = 3'b000;
  logic       flashReq = 1'b0;
  logic [2:0] ledR, ledY, ledG, pedWalk;
  logic [7:0] secondsLeft;
  logic [2:0] stateOut;
  logic [1:0] phaseOut;

  int nCompared = 0;
  int nMismatched = 0;
  int edgeNo = 0;

  int mKind, mPhase, mSec, mSub, mReq, mWalk, mBlink;
  int mBtnHist[3];
  int mFlHist[2];

  traffic_multi_phase #(
    .CLK_HZ(CLK_HZ), .N_PHASES(N), .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW),
    .T_ALL_RED(T_ALL_RED), .T_PED_WALK(T_PED), .T_MIN_GREEN(T_MIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ped_btn(pedBtn),
`ifdef TRAFFIC_FLASH_EN
    .flash_req(flashReq),
`endif
    .led_r(ledR),
    .led_y(ledY),
    .led_g(ledG),
    .ped_walk(pedWalk),
    .seconds_left(secondsLeft),
    .state(stateOut),
    .phase(phaseOut)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mKind = K_ALL_RED; mPhase = 0; mSec = T_ALL_RED; mSub = 0;
    mReq = 0; mWalk = 0; mBlink = 0;
    mBtnHist[0] = 0; mBtnHist[1] = 0; mBtnHist[2] = 0;
    mFlHist[0] = 0; mFlHist[1] = 0;
  endtask

  // One clock edge of the reference: seconds end every CLK_HZ cycles; requests arrive after sync delay.
  task automatic modelEdge(input int btn, input int fl, input bit rstLvl);
    int rise, clr;
    bit tick;
    if (rstLvl) begin
      modelReset();
    end else begin
      rise = mBtnHist[1] & ~mBtnHist[2];
      clr  = 0;
      tick = (mSub == CLK_HZ - 1);
      if (mFlHist[1] != 0) begin
        if (mKind != K_FLASH) begin
          mKind = K_FLASH; mBlink = 1; mSec = 0; mWalk = 0;
        end else if (tick) begin
          mBlink = 1 - mBlink;
        end
      end else if (mKind == K_FLASH) begin
        mKind = K_ALL_RED; mSec = T_ALL_RED;
      end else if (tick) begin
        if (mSec > 1 && !(mKind == K_GREEN && mReq != 0 && (T_GREEN - mSec + 1) >= T_MIN)) begin
          mSec = mSec - 1;
        end else begin
          case (mKind)
            K_GREEN:  begin mKind = K_YELLOW; mSec = T_YELLOW; end
            K_YELLOW: begin mKind = K_ALL_RED; mSec = T_ALL_RED; mPhase = (mPhase + 1) % N; end
            K_ALL_RED: begin
              if (mReq != 0) begin
                mKind = K_PED; mSec = T_PED; mWalk = mReq; clr = mReq;
              end else begin
                mKind = K_GREEN; mSec = T_GREEN;
              end
            end
            default: begin mKind = K_GREEN; mSec = T_GREEN; mWalk = 0; end
          endcase
        end
      end
      mReq = (mReq & ~clr) | rise;
      mBtnHist[2] = mBtnHist[1]; mBtnHist[1] = mBtnHist[0]; mBtnHist[0] = btn;
      mFlHist[1] = mFlHist[0]; mFlHist[0] = fl;
      mSub = tick ? 0 : mSub + 1;
    end
  endtask

  function automatic logic [31:0] expVec();
    logic [2:0] r, y, g, w;
    r = 3'b111; y = 3'b000; g = 3'b000; w = 3'b000;
    case (mKind)
      K_GREEN:  begin r[mPhase] = 1'b0; g[mPhase] = 1'b1; end
      K_YELLOW: begin r[mPhase] = 1'b0; y[mPhase] = 1'b1; end
      K_PED:    w = 3'(mWalk);
      K_FLASH:  begin r = 3'b000; y = (mBlink != 0) ? 3'b111 : 3'b000; end
      default: ;
    endcase
    return {7'd0, r, y, g, w, 8'(mSec), 3'(mKind), 2'(mPhase)};
  endfunction

  function automatic logic [31:0] obsVec();
    return {7'd0, ledR, ledY, ledG, pedWalk, secondsLeft, stateOut, phaseOut};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge(int'(pedBtn), int'(flashReq), rst);
    edgeNo++;
    #1;
    checkOutput($sformatf("cycle%0d", edgeNo), obsVec(), expVec());
    checkOutput("walkUnderRed", {31'd0, (pedWalk == 3'b000) || (ledR == 3'b111)}, 32'd1);
  endtask

  task automatic stepTo(input int n);
    while (edgeNo < n) stepCycle();
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input int cycles);
    pedBtn = mask;
    for (int k = 0; k < cycles; k++) stepCycle();
    pedBtn = 3'b000;
  endtask

  task automatic checkState(input string tag, input int st, input int ph, input int sec);
    checkOutput({tag, "_state"}, {29'd0, stateOut}, 32'(st));
    checkOutput({tag, "_phase"}, {30'd0, phaseOut}, 32'(ph));
    checkOutput({tag, "_sec"}, {24'd0, secondsLeft}, 32'(sec));
  endtask

  initial begin
    int btnLeft, flLeft;
    modelReset();
    stepCycle();
    stepCycle();
    checkState("reset", 2, 0, 1);
    checkOutput("reset_lamps", {20'd0, ledR, ledY, ledG, pedWalk}, {20'd0, 12'b111_000_000_000});
    rst = 1'b0;
    edgeNo = 0;

    $display("[TB] free-running cycle");
    stepTo(9);   checkState("ar0_end", 2, 0, 1);
    stepTo(10);  checkState("g0_start", 0, 0, 4);
    checkOutput("g0_green", {29'd0, ledG}, 32'b001);
    stepTo(20);  checkState("g0_sec3", 0, 0, 3);
    stepTo(50);  checkState("y0_start", 1, 0, 2);
    stepTo(70);  checkState("ar_p1", 2, 1, 1);
    stepTo(80);  checkState("g1_start", 0, 1, 4);
    stepTo(220); checkState("g0_wrap", 0, 0, 4);

    $display("[TB] early green cut-off and walk");
    stepTo(229); applyStimulus(3'b010, 3);
    stepTo(239); checkState("g0_cut_pre", 0, 0, 3);
    stepTo(240); checkState("g0_cut", 1, 0, 2);
    stepTo(270); checkState("ped1", 3, 1, 3);
    checkOutput("ped1_walk", {29'd0, pedWalk}, 32'b010);
    stepTo(300); checkState("g1_after_ped", 0, 1, 4);

    $display("[TB] two presses during yellow");
    stepTo(345); applyStimulus(3'b101, 3);
    stepTo(370); checkOutput("ped2_walk", {29'd0, pedWalk}, 32'b101);
    stepTo(440); checkState("g2_full", 1, 2, 2);
    stepTo(470); checkState("no_ped", 0, 0, 4);

    $display("[TB] press during walk is deferred");
    stepTo(475); applyStimulus(3'b010, 1);
    stepTo(490); checkState("g0_cut2", 1, 0, 2);
    stepTo(525); applyStimulus(3'b100, 1);
    stepTo(535); checkOutput("ped3_walk", {29'd0, pedWalk}, 32'b010);
    stepTo(600); checkOutput("ped4_walk", {29'd0, pedWalk}, 32'b100);

    $display("[TB] bouncing button");
    stepTo(632); applyStimulus(3'b001, 1);
    stepCycle(); applyStimulus(3'b001, 1);
    stepCycle(); applyStimulus(3'b001, 1);
    stepTo(680); checkOutput("ped5_walk", {29'd0, pedWalk}, 32'b001);
    stepTo(750); checkState("single_ped", 1, 0, 2);
    stepTo(780); checkState("g1_no_ped", 0, 1, 4);

    $display("[TB] reset during walk");
    stepTo(782); applyStimulus(3'b010, 1);
    stepTo(831); checkState("ped6", 3, 2, 3);
    stepTo(835);
    #1 rst = 1'b1;
    #1;
    checkState("async_rst", 2, 0, 1);
    checkOutput("async_rst_walk", {29'd0, pedWalk}, 32'd0);
    checkOutput("async_rst_red", {29'd0, ledR}, 32'b111);
    modelReset();
    stepCycle();
    stepCycle();
    rst = 1'b0;
    edgeNo = 0;

`ifdef TRAFFIC_FLASH_EN
    $display("[TB] flash override");
    stepTo(20);
    flashReq = 1'b1;
    stepTo(22); checkOutput("fl_pre", {29'd0, stateOut}, 32'd0);
    stepTo(23); checkState("fl_on", 4, 0, 0);
    checkOutput("fl_y1", {29'd0, ledY}, 32'b111);
    checkOutput("fl_r", {29'd0, ledR}, 32'd0);
    stepTo(30); checkOutput("fl_y0", {29'd0, ledY}, 32'b000);
    stepTo(40); checkOutput("fl_y1b", {29'd0, ledY}, 32'b111);
    stepTo(70);
    flashReq = 1'b0;
    stepTo(72); checkOutput("fl_hold", {29'd0, stateOut}, 32'd4);
    stepTo(73); checkState("fl_off", 2, 0, 1);
    stepTo(80); checkState("fl_resume", 0, 0, 4);
`endif

    $display("[TB] random presses");
    btnLeft = 0;
    flLeft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        pedBtn = 3'b000; btnLeft = 0;
        flashReq = 1'b0; flLeft = 0;
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
      end
      if (btnLeft == 0 && $urandom_range(0, 29) == 0) begin
        pedBtn = 3'($urandom_range(1, 7));
        btnLeft = $urandom_range(1, 3);
      end
`ifdef TRAFFIC_FLASH_EN
      if (flLeft == 0 && $urandom_range(0, 399) == 0) begin
        flashReq = 1'b1;
        flLeft = $urandom_range(15, 60);
      end
`endif
      stepCycle();
      if (btnLeft > 0) begin
        btnLeft--;
        if (btnLeft == 0) pedBtn = 3'b000;
      end
      if (flLeft > 0) begin
        flLeft--;
        if (flLeft == 0) flashReq = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
